// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for the digit-serial add/subtract unit.
//   master : requester side   - drives start, sub, a, b, cin; observes busy, done, sum, cout, ovf
//   slave  : serial_adder side - the inverse
// WIDTH must match the WIDTH of the attached serial_adder.
interface serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract, WIDTH-bit operands processed DIGIT bits per clock
// through a DIGIT-wide ripple slice with a registered carry between digits (N = WIDTH/DIGIT).
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : serial_adder_if.slave
//          start/sub/a/b/cin - request, sampled only in IDLE or DONE
//          busy              - high while digits are processed
//          done              - one-cycle pulse, sum/cout/ovf valid
//          sum/cout/ovf      - result, raw MSB carry, signed overflow; held until next result
// WIDTH must be an integer multiple of DIGIT.
module serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  serial_adder_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   dsum;
  logic             c_msb;
  logic             last;
  logic [WIDTH-1:0] ins;
  logic [WIDTH-1:0] part_next;

  // Digit slice and the partial result with this digit shifted in from the MSB end.
  always_comb begin
    dsum = {1'b0, op_a_q[DIGIT-1:0]} + {1'b0, op_b_q[DIGIT-1:0]}
         + {{DIGIT{1'b0}}, carry_q};
    // Carry into the top bit of the slice recovered from its sum bit; on the last digit
    // this is the carry into bit WIDTH-1 (and equals carry_q when DIGIT=1).
    c_msb = dsum[DIGIT-1] ^ op_a_q[DIGIT-1] ^ op_b_q[DIGIT-1];
    last  = (cnt_q == CW'(N - 1));
    ins   = '0;
    ins[WIDTH-1 -: DIGIT] = dsum[DIGIT-1:0];
    part_next = (part_q >> DIGIT) | ins;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
    bus.sum  = sum_q;
    bus.cout = cout_q;
    bus.ovf  = ovf_q;
  end

  // Datapath next values
  always_comb begin
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    part_d  = part_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          // Subtract as a + ~b + ~cin: invert b and fold sub into the initial carry.
          op_a_d  = bus.a;
          op_b_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        op_a_d  = op_a_q >> DIGIT;
        op_b_d  = op_b_q >> DIGIT;
        part_d  = part_next;
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          sum_d  = part_next;
          cout_d = dsum[DIGIT];
          ovf_d  = c_msb ^ dsum[DIGIT];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      part_q  <= part_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder (WIDTH=8, DIGIT=2).
module tb_serial_adder;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic: {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
    int ua, ub, sa, sb, r, sr;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      r  = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      c  = (r > (1 << W) - 1);
    end else begin
      r  = ua - ub - int'(cin);
      sr = sa - sb - int'(cin);
      c  = (r >= 0);          // no borrow
    end
    o = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    return {o, c, W'(r)};
  endfunction

  // Transaction-level model: an accepted request produces its result N clocks later.
  logic         m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] m_sum  = '0;
  logic [W+1:0] m_pend = '0;
  int           m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0; m_left <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        {m_ovf, m_cout, m_sum} <= m_pend;
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_pend <= ref_op(bus.a, bus.b, bus.cin, bus.sub);
        m_busy <= 1'b1;
        m_left <= N;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("sum",  32'(bus.sum),  32'(m_sum));
      chk("cout", 32'(bus.cout), 32'(m_cout));
      chk("ovf",  32'(bus.ovf),  32'(m_ovf));
    end
  end

  // Issue one operation from idle, then check latency, busy length and literal result.
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                    input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
    int lat, nbusy;
    @(negedge clk);
    bus.a = ta; bus.b = tb_; bus.cin = tc; bus.sub = ts; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = '0; bus.b = '0;
    lat = 0; nbusy = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    chk("op_latency", 32'(lat), 32'(N));
    chk("op_busy_cycles", 32'(nbusy), 32'(N));
    chk("op_sum", 32'(bus.sum), 32'(es));
    chk("op_cout", 32'(bus.cout), 32'(ec));
    chk("op_ovf", 32'(bus.ovf), 32'(eo));
    @(negedge clk);
  endtask

  initial begin
    int lat, ndone;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_sum",  32'(bus.sum),  0);
    chk("rst_cout", 32'(bus.cout), 0);
    chk("rst_ovf",  32'(bus.ovf),  0);
    rst = 1'b0;
    chk_en = 1'b1;

    op(8'h3C, 8'h15, 1'b0, 1'b0, 8'h51, 1'b0, 1'b0);
    op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    op(8'h05, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0);
    op(8'h05, 8'h02, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0);

    // start while busy is ignored
    @(negedge clk);
    bus.a = 8'h3C; bus.b = 8'h15; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.a = 8'hAA; bus.b = 8'h55; bus.sub = 1'b1; bus.cin = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    repeat (8) begin
      if (bus.done) begin
        ndone++;
        chk("ign_sum", 32'(bus.sum), 32'h51);
      end
      @(negedge clk);
    end
    chk("ign_done_count", 32'(ndone), 1);

    // reset mid-run aborts
    @(negedge clk);
    bus.a = 8'h12; bus.b = 8'h34; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_sum",  32'(bus.sum),  0);
    chk("abort_done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 0);

    // back-to-back: start in the done cycle
    @(negedge clk);
    bus.a = 8'h3C; bus.b = 8'h15; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 20) begin @(negedge clk); lat++; end
    chk("b2b_lat1", 32'(lat), 32'(N));
    bus.a = 8'h10; bus.b = 8'h20; bus.sub = 1'b1; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_no_gap", 32'(bus.busy), 1);
    chk("b2b_hold", 32'(bus.sum), 32'h51);
    lat = 0;
    while (!bus.done && lat < 20) begin @(negedge clk); lat++; end
    chk("b2b_lat2", 32'(lat), 32'(N));
    chk("b2b_sum", 32'(bus.sum), 32'hF0);
    @(negedge clk);

    // randomized traffic, including ignored starts and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom);
      bus.sub   = 1'($urandom);
      bus.start = ($urandom_range(3) == 0);
      rst       = ($urandom_range(299) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
